// File: rtl/matmul_calc_pkg.sv
// Shared types and widths for the matmul accelerator and its APB initiator.
package matmul_calc_pkg;

    localparam int unsigned DATA_WIDTH = 32;
    localparam int unsigned BUS_WIDTH  = 64;
    localparam int unsigned ADDR_WIDTH = 32;
    localparam int unsigned STRB_WIDTH = BUS_WIDTH / 8;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS
    } apb_state_e;

    typedef struct packed {
        logic                  write;
        logic [ADDR_WIDTH-1:0] addr;
        logic [BUS_WIDTH-1:0]  wdata;
        logic [STRB_WIDTH-1:0] strb;
    } apb_req_t;

endpackage

// File: rtl/matmul_apb_req_fifo.sv
// Small request FIFO holding pending APB commands for matmul_apb_master.
module matmul_apb_req_fifo
    import matmul_calc_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic     clk_i,
    input  logic     rst_i,
    input  logic     push_i,
    input  apb_req_t data_i,
    input  logic     pop_i,
    output apb_req_t data_o,
    output logic     full_o,
    output logic     empty_o
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    apb_req_t         r_mem [DEPTH];
    logic [PTR_W-1:0] r_wptr;
    logic [PTR_W-1:0] r_rptr;
    logic [CNT_W-1:0] r_count;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
        return (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + PTR_W'(1);
    endfunction

    // Payload storage; no reset needed because occupancy lives in r_count.
    always_ff @(posedge clk_i) begin
        if (push_i) begin
            r_mem[r_wptr] <= data_i;
        end
    end

    // Pointers and occupancy; push and pop together leave the count unchanged.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (push_i) begin
                r_wptr <= ptr_inc(r_wptr);
            end
            if (pop_i) begin
                r_rptr <= ptr_inc(r_rptr);
            end
            unique case ({push_i, pop_i})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign data_o  = r_mem[r_rptr];
    assign full_o  = (r_count == CNT_W'(DEPTH));
    assign empty_o = (r_count == '0);

endmodule

// File: rtl/matmul_apb_master.sv
// APB initiator for the matmul accelerator: buffers commands, runs SETUP/ACCESS,
// returns read data and error status on a valid/ready response channel.
// Optional ACCESS-phase timeout is enabled by defining MATMUL_APB_TIMEOUT_EN.
module matmul_apb_master
    import matmul_calc_pkg::*;
#(
    parameter int unsigned REQ_DEPTH   = 2,
    parameter int unsigned TIMEOUT_CYC = 64
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic                  req_write_i,
    input  logic [ADDR_WIDTH-1:0] req_addr_i,
    input  logic [BUS_WIDTH-1:0]  req_wdata_i,
    input  logic [STRB_WIDTH-1:0] req_strb_i,
    output logic                  rsp_valid_o,
    input  logic                  rsp_ready_i,
    output logic [BUS_WIDTH-1:0]  rsp_rdata_o,
    output logic                  rsp_err_o,
    output logic                  psel_o,
    output logic                  penable_o,
    output logic                  pwrite_o,
    output logic [ADDR_WIDTH-1:0] paddr_o,
    output logic [BUS_WIDTH-1:0]  pwdata_o,
    output logic [STRB_WIDTH-1:0] pstrb_o,
    input  logic                  pready_i,
    input  logic                  pslverr_i,
    input  logic [BUS_WIDTH-1:0]  prdata_i
);

    if ((BUS_WIDTH % DATA_WIDTH) != 0 || (BUS_WIDTH % 8) != 0) begin : g_bad_width
        $fatal(1, "BUS_WIDTH must be a multiple of DATA_WIDTH and of 8");
    end
    if (REQ_DEPTH < 1 || REQ_DEPTH > 2) begin : g_bad_depth
        $fatal(1, "REQ_DEPTH must be 1 or 2");
    end
    if (TIMEOUT_CYC == 0) begin : g_bad_timeout
        $fatal(1, "TIMEOUT_CYC must be non-zero");
    end

    apb_state_e            r_state;
    apb_state_e            w_state_d;
    apb_req_t              w_in;
    apb_req_t              w_fifo_head;
    apb_req_t              w_head;
    logic                  w_full;
    logic                  w_empty;
    logic                  w_accept;
    logic                  w_head_valid;
    logic                  w_take;
    logic                  w_done;
    logic                  w_tmo;
    logic                  w_rsp_free;
    logic                  w_fifo_push;
    logic                  w_fifo_pop;
    logic                  r_pwrite;
    logic [ADDR_WIDTH-1:0] r_paddr;
    logic [BUS_WIDTH-1:0]  r_pwdata;
    logic [STRB_WIDTH-1:0] r_pstrb;
    logic                  r_rsp_valid;
    logic [BUS_WIDTH-1:0]  r_rsp_rdata;
    logic                  r_rsp_err;

    // Pack the incoming command into the buffer payload format.
    always_comb begin
        w_in       = '0;
        w_in.write = req_write_i;
        w_in.addr  = req_addr_i;
        w_in.wdata = req_wdata_i;
        w_in.strb  = req_strb_i;
    end

    assign req_ready_o  = !w_full;
    assign w_accept     = req_valid_i && !w_full;
    // An empty buffer forwards the incoming command so SETUP follows acceptance directly.
    assign w_head_valid = !w_empty || w_accept;
    assign w_head       = w_empty ? w_in : w_fifo_head;
    assign w_fifo_push  = w_accept && !(w_empty && w_take);
    assign w_fifo_pop   = w_take && !w_empty;
    assign w_rsp_free   = !r_rsp_valid || rsp_ready_i;

    matmul_apb_req_fifo #(
        .DEPTH (REQ_DEPTH)
    ) u_req_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (w_fifo_push),
        .data_i  (w_in),
        .pop_i   (w_fifo_pop),
        .data_o  (w_fifo_head),
        .full_o  (w_full),
        .empty_o (w_empty)
    );

`ifdef MATMUL_APB_TIMEOUT_EN
    localparam int unsigned TMO_W = $clog2(TIMEOUT_CYC + 1);
    logic [TMO_W-1:0] r_tmo_cnt;

    // Counts ACCESS cycles of the current transfer; zero on the first ACCESS cycle.
    always_ff @(posedge clk_i) begin
        if (rst_i || r_state != ACCESS) begin
            r_tmo_cnt <= '0;
        end else begin
            r_tmo_cnt <= r_tmo_cnt + TMO_W'(1);
        end
    end

    assign w_tmo = (r_state == ACCESS) && !pready_i && (r_tmo_cnt == TMO_W'(TIMEOUT_CYC - 1));
`else
    assign w_tmo = 1'b0;
`endif

    // FSM state register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_d;
        end
    end

    // Next state, head pop and completion strobe.
    always_comb begin
        w_state_d = r_state;
        w_take    = 1'b0;
        w_done    = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (w_head_valid && w_rsp_free) begin
                    w_take    = 1'b1;
                    w_state_d = SETUP;
                end
            end
            SETUP: begin
                w_state_d = ACCESS;
            end
            ACCESS: begin
                if (pready_i || w_tmo) begin
                    w_done = 1'b1;
                    // Chain straight into SETUP only while the consumer is draining
                    // responses; otherwise wait in IDLE for the response to be taken.
                    if (w_head_valid && rsp_ready_i) begin
                        w_take    = 1'b1;
                        w_state_d = SETUP;
                    end else begin
                        w_state_d = IDLE;
                    end
                end
            end
            default: begin
                w_state_d = IDLE;
            end
        endcase
    end

    // APB address/data/control, held from SETUP through the completing ACCESS.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_pwrite <= 1'b0;
            r_paddr  <= '0;
            r_pwdata <= '0;
            r_pstrb  <= '0;
        end else if (w_take) begin
            r_pwrite <= w_head.write;
            r_paddr  <= w_head.addr;
            r_pwdata <= w_head.wdata;
            r_pstrb  <= w_head.write ? w_head.strb : '0;
        end
    end

    // Response registers; a completion in the consume cycle reloads them.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b0;
        end else if (w_done) begin
            r_rsp_valid <= 1'b1;
            r_rsp_rdata <= (r_pwrite || w_tmo) ? '0 : prdata_i;
            r_rsp_err   <= pslverr_i || w_tmo;
        end else if (rsp_ready_i) begin
            r_rsp_valid <= 1'b0;
        end
    end

    assign psel_o      = (r_state != IDLE);
    assign penable_o   = (r_state == ACCESS);
    assign pwrite_o    = r_pwrite;
    assign paddr_o     = r_paddr;
    assign pwdata_o    = r_pwdata;
    assign pstrb_o     = r_pstrb;
    assign rsp_valid_o = r_rsp_valid;
    assign rsp_rdata_o = r_rsp_rdata;
    assign rsp_err_o   = r_rsp_err;

endmodule

// File: tb/tb_matmul_apb_master.sv
// Self-checking bench for matmul_apb_master: queue-based reference model compared every
// cycle, plus directed scenarios with hand-computed literal expectations.
module tb_matmul_apb_master;

    localparam int DEPTH = 2;
    localparam int TMO   = 64;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [31:0] req_addr;
    logic [63:0] req_wdata;
    logic [7:0]  req_strb;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [63:0] rsp_rdata;
    logic        rsp_err;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [31:0] paddr;
    logic [63:0] pwdata;
    logic [7:0]  pstrb;
    logic        pready;
    logic        pslverr;
    logic [63:0] prdata;

    int n_checks = 0;
    int n_errors = 0;
    bit chk_en   = 0;

    // APB slave behaviour knobs
    int          cfg_waits = 0;
    logic [63:0] cfg_rdata = '0;
    bit          cfg_err   = 0;
    int          s_n       = 0;

    always #5 clk = ~clk;

    matmul_apb_master #(
        .REQ_DEPTH   (DEPTH),
        .TIMEOUT_CYC (TMO)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .req_valid_i (req_valid),
        .req_ready_o (req_ready),
        .req_write_i (req_write),
        .req_addr_i  (req_addr),
        .req_wdata_i (req_wdata),
        .req_strb_i  (req_strb),
        .rsp_valid_o (rsp_valid),
        .rsp_ready_i (rsp_ready),
        .rsp_rdata_o (rsp_rdata),
        .rsp_err_o   (rsp_err),
        .psel_o      (psel),
        .penable_o   (penable),
        .pwrite_o    (pwrite),
        .paddr_o     (paddr),
        .pwdata_o    (pwdata),
        .pstrb_o     (pstrb),
        .pready_i    (pready),
        .pslverr_i   (pslverr),
        .prdata_i    (prdata)
    );

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        bit          w;
        logic [31:0] a;
        logic [63:0] d;
        logic [7:0]  s;
    } mreq_t;

    mreq_t       m_q[$];
    mreq_t       m_cur;
    int          m_phase = 0;  // 0 idle, 1 select, 2 enable
    bit          m_rv = 0;
    logic [63:0] m_rd = '0;
    bit          m_re = 0;
    int          m_tmo = 0;

    // Model advances on each rising edge using the inputs present during that cycle.
    initial begin
        forever begin
            @(posedge clk);
            if (rst) begin
                m_q.delete();
                m_phase = 0;
                m_rv    = 0;
                m_rd    = '0;
                m_re    = 0;
                m_tmo   = 0;
            end else begin
                bit    free;
                bit    to;
                mreq_t in;
                free = !m_rv || rsp_ready;
                if (req_valid && m_q.size() < DEPTH) begin
                    in.w = req_write; in.a = req_addr; in.d = req_wdata; in.s = req_strb;
                    m_q.push_back(in);
                end
                if (m_rv && rsp_ready) m_rv = 0;
                if (m_phase == 0) begin
                    if (m_q.size() > 0 && free) begin
                        m_cur   = m_q.pop_front();
                        m_phase = 1;
                    end
                end else if (m_phase == 1) begin
                    m_phase = 2;
                    m_tmo   = 0;
                end else begin
                    to = 0;
`ifdef MATMUL_APB_TIMEOUT_EN
                    to = !pready && (m_tmo == TMO - 1);
`endif
                    if (pready || to) begin
                        m_rv = 1;
                        m_rd = (m_cur.w || to) ? 64'd0 : prdata;
                        m_re = to ? 1'b1 : pslverr;
                        if (m_q.size() > 0 && rsp_ready) begin
                            m_cur   = m_q.pop_front();
                            m_phase = 1;
                        end else begin
                            m_phase = 0;
                        end
                    end else begin
                        m_tmo++;
                    end
                end
            end
        end
    end

    // Compare DUT outputs against the model mid-cycle.
    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                chk("m_psel", psel, m_phase != 0);
                chk("m_penable", penable, m_phase == 2);
                chk("m_req_ready", req_ready, m_q.size() < DEPTH);
                chk("m_rsp_valid", rsp_valid, m_rv);
                if (m_phase != 0) begin
                    chk("m_paddr", paddr, m_cur.a);
                    chk("m_pwrite", pwrite, m_cur.w);
                    chk("m_pstrb", pstrb, m_cur.w ? m_cur.s : 8'h00);
                    if (m_cur.w) chk("m_pwdata", pwdata, m_cur.d);
                end
                if (m_rv) begin
                    chk("m_rsp_rdata", rsp_rdata, m_rd);
                    chk("m_rsp_err", rsp_err, m_re);
                end
            end
        end
    end

    // ---------------- APB slave responder ----------------
    initial begin
        pready  = 0;
        pslverr = 0;
        prdata  = '0;
        forever begin
            @(posedge clk);
            #1;
            if (penable) begin
                s_n++;
                if (s_n == cfg_waits + 1) begin
                    pready  = 1;
                    prdata  = cfg_rdata;
                    pslverr = cfg_err;
                    s_n     = 0;
                end else begin
                    pready  = 0;
                    prdata  = {$urandom, $urandom};
                    pslverr = 1'($urandom_range(0, 1));
                end
            end else begin
                s_n     = 0;
                pready  = 0;
                pslverr = 0;
                prdata  = {$urandom, $urandom};
            end
        end
    end

    // Present one command, wait (bounded) until accepted, then drop valid.
    task automatic put_req(input bit w, input logic [31:0] a, input logic [63:0] d,
                           input logic [7:0] s);
        req_valid = 1; req_write = w; req_addr = a; req_wdata = d; req_strb = s;
        for (int i = 0; i < 50; i++) begin
            if (req_ready) break;
            step();
        end
        chk("req_accept", req_ready, 1'b1);
        step();
        req_valid = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    int acc;
    int run;
    int best;
    int nrsp;
    bit saw_nr;
    bit bad;

    initial begin
        rst = 1; req_valid = 0; req_write = 0; req_addr = '0; req_wdata = '0; req_strb = '0;
        rsp_ready = 1;
        step();
        chk_en = 1;
        step();
        step();
        chk("rst_psel", psel, 1'b0);
        chk("rst_penable", penable, 1'b0);
        chk("rst_paddr", paddr, 32'h0);
        chk("rst_rsp_valid", rsp_valid, 1'b0);
        chk("rst_req_ready", req_ready, 1'b1);
        rst = 0;
        step();

        // Single write, zero wait states
        put_req(1, 32'h10, 64'h0000_0002_0000_0001, 8'hFF);
        chk("wr_setup_psel", psel, 1'b1);
        chk("wr_setup_penable", penable, 1'b0);
        chk("wr_paddr", paddr, 32'h10);
        step();
        chk("wr_access_penable", penable, 1'b1);
        chk("wr_pwdata", pwdata, 64'h0000_0002_0000_0001);
        step();
        chk("wr_rsp_valid", rsp_valid, 1'b1);
        chk("wr_rsp_err", rsp_err, 1'b0);
        chk("wr_rsp_rdata", rsp_rdata, 64'h0);
        chk("wr_idle_psel", psel, 1'b0);
        step();
        chk("wr_rsp_consumed", rsp_valid, 1'b0);

        // Read with 3 wait states
        cfg_waits = 3;
        cfg_rdata = 64'hDEAD_BEEF_0000_0005;
        put_req(0, 32'h20, 64'h1234, 8'hFF);
        chk("rd_pstrb", pstrb, 8'h00);
        acc = 0;
        for (int i = 0; i < 20; i++) begin
            if (rsp_valid) break;
            if (penable) acc++;
            if (psel) chk("rd_paddr_stable", paddr, 32'h20);
            step();
        end
        chk("rd_access_cycles", acc, 4);
        chk("rd_rsp_valid", rsp_valid, 1'b1);
        chk("rd_rsp_rdata", rsp_rdata, 64'hDEAD_BEEF_0000_0005);
        step();

        // Back-to-back writes
        cfg_waits = 0;
        run = 0; best = 0; nrsp = 0; saw_nr = 0;
        fork
            begin
                put_req(1, 32'h100, 64'hA, 8'h01);
                put_req(1, 32'h108, 64'hB, 8'h03);
                put_req(1, 32'h110, 64'hC, 8'h0F);
                put_req(1, 32'h118, 64'hD, 8'hF0);
            end
            begin
                for (int i = 0; i < 14; i++) begin
                    if (psel) begin
                        run++;
                        if (run > best) best = run;
                    end else begin
                        run = 0;
                    end
                    if (!req_ready) saw_nr = 1;
                    if (rsp_valid) nrsp++;
                    step();
                end
            end
        join
        chk("b2b_psel_run", best, 8);
        chk("b2b_ready_low", saw_nr, 1'b1);
        chk("b2b_rsp_count", nrsp, 4);

        // Backpressure with slave error
        cfg_rdata = 64'h1111_2222_3333_4444;
        cfg_err   = 1;
        rsp_ready = 0;
        put_req(0, 32'h30, 64'h0, 8'hFF);
        put_req(1, 32'h40, 64'h5555, 8'h0F);
        step();
        cfg_err = 0;
        chk("bp_rsp_valid", rsp_valid, 1'b1);
        chk("bp_rsp_err", rsp_err, 1'b1);
        chk("bp_rsp_rdata", rsp_rdata, 64'h1111_2222_3333_4444);
        for (int i = 0; i < 4; i++) begin
            chk("bp_hold_psel", psel, 1'b0);
            chk("bp_hold_valid", rsp_valid, 1'b1);
            chk("bp_hold_err", rsp_err, 1'b1);
            step();
        end
        rsp_ready = 1;
        step();
        chk("bp_next_psel", psel, 1'b1);
        chk("bp_next_paddr", paddr, 32'h40);
        chk("bp_consumed", rsp_valid, 1'b0);
        step();
        step();
        chk("bp_wr_rsp_valid", rsp_valid, 1'b1);
        chk("bp_wr_rsp_err", rsp_err, 1'b0);
        step();

        // Reset during ACCESS with a command queued
        cfg_waits = 5;
        put_req(0, 32'h50, 64'h0, 8'hFF);
        put_req(1, 32'h60, 64'h6, 8'hFF);
        chk("rs_in_access", penable, 1'b1);
        rst = 1;
        step();
        rst = 0;
        chk("rs_psel", psel, 1'b0);
        chk("rs_penable", penable, 1'b0);
        chk("rs_rsp_valid", rsp_valid, 1'b0);
        chk("rs_req_ready", req_ready, 1'b1);
        bad = 0;
        for (int i = 0; i < 8; i++) begin
            if (psel || rsp_valid) bad = 1;
            step();
        end
        chk("rs_queue_dropped", bad, 1'b0);

`ifdef MATMUL_APB_TIMEOUT_EN
        // ACCESS timeout with a slave that never answers
        cfg_waits = 1000;
        put_req(0, 32'h70, 64'h0, 8'hFF);
        acc = 0;
        for (int i = 0; i < 200; i++) begin
            if (rsp_valid) break;
            if (penable) acc++;
            step();
        end
        chk("to_access_cycles", acc, TMO);
        chk("to_rsp_valid", rsp_valid, 1'b1);
        chk("to_rsp_err", rsp_err, 1'b1);
        chk("to_rsp_rdata", rsp_rdata, 64'h0);
        chk("to_idle_psel", psel, 1'b0);
        cfg_waits = 0;
        step();
`endif

        step();
        step();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
